fifo_word_packer: RTL and testbench

//  Downstream consumer of the 16x8 byte FIFO: drains bytes via fifo_re/fifo_empty
//  and packs BYTES_PER_WORD of them little-endian into one word on a valid/ready port.

---
 rtl/fifo_word_packer_pkg.sv | 17 +
 rtl/fifo_word_packer_flush_timer.sv | 28 ++
 rtl/fifo_word_packer.sv | 102 ++++++++++
 tb/tb_fifo_word_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared constants and state encoding for the byte-to-word packer and the
// 16x8 byte FIFO it drains.
package fifo_word_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } pack_state_t;

    localparam int FIFO_RD_LAT = 1;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_WIDTH  = 8;

    // Wide enough for byte counts 0..8 and the word_bytes port.
    localparam int CNT_W = 4;

endpackage

// File: rtl/fifo_word_packer_flush_timer.sv
// Idle-cycle counter for the partial-word flush; only built when
// FIFO_PACKER_FLUSH_EN is defined. expire is high on the TIMEOUT-th idle cycle.
module fifo_word_packer_flush_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_cnt;

    assign expire = count_en && (idle_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idle_cnt <= '0;
        end else if (count_en && !expire) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a 1-cycle-latency byte FIFO and packs BYTES_PER_WORD bytes little-endian
// onto a valid/ready word port. Define FIFO_PACKER_FLUSH_EN to flush idle partial words.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int DATA_W         = FIFO_WIDTH,
    parameter int BYTES_PER_WORD = 4,
    parameter int FLUSH_TIMEOUT  = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fifo_empty,
    input  logic [DATA_W-1:0]                  fifo_data,
    output logic                               fifo_re,
    output logic [DATA_W*BYTES_PER_WORD-1:0]   word_out,
    output logic [3:0]                         word_bytes,
    output logic                               word_valid,
    input  logic                               word_ready
);

    localparam logic [CNT_W-1:0] BPW_C    = CNT_W'(BYTES_PER_WORD);
    localparam logic [CNT_W:0]   BPW_WIDE = (CNT_W + 1)'(BYTES_PER_WORD);

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || FLUSH_TIMEOUT < 1) begin : g_param_check
        $error("fifo_word_packer: BYTES_PER_WORD must be 2..8, FLUSH_TIMEOUT >= 1");
    end

    pack_state_t      state;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   committed;
    logic             rd_pend;
    logic             flush_expire;

    // Sink handshake: a word moves when word_valid && word_ready at a rising edge;
    // word_out/word_bytes stay frozen while valid is high and ready is low.

    // The read still in flight counts toward the word so we never over-read.
    assign committed = {1'b0, byte_cnt} + {{CNT_W{1'b0}}, rd_pend};
    assign cnt_next  = byte_cnt + 1'b1;
    assign fifo_re   = !rst && !fifo_empty && (state == FILL) && (committed < BPW_WIDE);

`ifdef FIFO_PACKER_FLUSH_EN
    fifo_word_packer_flush_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en ((state == FILL) && (byte_cnt != '0) && !rd_pend && fifo_empty),
        .clear    (rd_pend || (state != FILL)),
        .expire   (flush_expire)
    );
`else
    assign flush_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            byte_cnt   <= '0;
            rd_pend    <= 1'b0;
            word_out   <= '0;
            word_bytes <= '0;
            word_valid <= 1'b0;
        end else begin
            rd_pend <= fifo_re;
            case (state)
                FILL: begin
                    if (rd_pend) begin
                        for (int k = 0; k < BYTES_PER_WORD; k++) begin
                            if (byte_cnt == CNT_W'(k)) begin
                                word_out[k*DATA_W +: DATA_W] <= fifo_data;
                            end
                        end
                        byte_cnt <= cnt_next;
                        if (cnt_next == BPW_C) begin
                            state      <= OUT;
                            word_valid <= 1'b1;
                            word_bytes <= BPW_C;
                        end
                    end else if (flush_expire) begin
                        // Unwritten upper lanes are already zero.
                        state      <= OUT;
                        word_valid <= 1'b1;
                        word_bytes <= byte_cnt;
                    end
                end
                OUT: begin
                    if (word_valid && word_ready) begin
                        state      <= FILL;
                        word_valid <= 1'b0;
                        word_bytes <= '0;
                        byte_cnt   <= '0;
                        word_out   <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural byte FIFO with 1-cycle read
// latency, word sink with controllable ready, and an expected-word scoreboard.
module tb_fifo_word_packer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_re;
    logic [31:0] word_out;
    logic [3:0]  word_bytes;
    logic        word_valid;
    logic        word_ready;

    logic [7:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          re_cnt = 0;
    int          re_on_empty = 0;
    logic [31:0] got_w [$];
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fifo_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .word_out   (word_out),
        .word_bytes (word_bytes),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1);
    end

    // Byte FIFO model and word sink monitor
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
            re_cnt    <= re_cnt + 1;
            if (fifo_empty) re_on_empty <= re_on_empty + 1;
        end
        if (word_valid && word_ready) got_w.push_back(word_out);
    end

    // Driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (waited < max_cyc) begin
            if (word_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            waited++;
        end
    endtask

    // Scoreboard: accepted words against expected queue, in order
    task automatic check_words();
        check("word_count", 64'(got_w.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_w.size() > 0) begin
            check("word_data", got_w.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_w.delete();
    endtask

    initial begin
        bit ok;
        int waited;
        int re_base;
        int valid_seen;
        int n;

        // Reset with data present in the FIFO
        rst = 1'b1;
        word_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick();
        tick();
        check("reset_re", fifo_re, 0);
        check("reset_valid", word_valid, 0);
        check("reset_word", word_out, 0);
        check("reset_bytes", word_bytes, 0);
        check("reset_re_cnt", re_cnt, 0);

        // Basic pack: four back-to-back reads, valid two cycles after the last
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("pack_re", fifo_re, (i < 4) ? 1 : 0);
            check("pack_valid", word_valid, (i == 5) ? 1 : 0);
            if (i < 5) tick();
        end
        check("pack_word", word_out, 32'h04030201);
        check("pack_bytes", word_bytes, 4);
        tick();
        exp_q.push_back(32'h04030201);
        check_words();
        check("pack_re_cnt", re_cnt, 4);

        // Backpressure: first word held 10 cycles, no reads while held
        word_ready = 1'b0;
        for (int b = 8'h10; b <= 8'h17; b++) push(8'(b));
        #1;
        wait_valid(20, ok, waited);
        check("bp_first_timeout", ok, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_word", word_out, 32'h13121110);
            check("bp_hold_valid", word_valid, 1);
            check("bp_hold_bytes", word_bytes, 4);
            check("bp_hold_re", fifo_re, 0);
            tick();
        end
        word_ready = 1'b1;
        tick();
        exp_q.push_back(32'h13121110);
        wait_valid(20, ok, waited);
        check("bp_second_timeout", ok, 1);
        check("bp_second_word", word_out, 32'h17161514);
        check("bp_second_bytes", word_bytes, 4);
        exp_q.push_back(32'h17161514);
        tick();
        check_words();
        check("bp_re_cnt", re_cnt, 12);

        // Starvation: three bytes then empty
        push(8'hAA); push(8'hBB); push(8'hCC);
        #1;
`ifdef FIFO_PACKER_FLUSH_EN
        wait_valid(40, ok, waited);
        check("flush_timeout", ok, 1);
        check("flush_latency", waited, 19);
        check("flush_word", word_out, 32'h00CCBBAA);
        check("flush_bytes", word_bytes, 3);
        exp_q.push_back(32'h00CCBBAA);
        tick();
`else
        valid_seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (word_valid) valid_seen++;
            tick();
        end
        check("starve_no_valid", valid_seen, 0);
        check("starve_byte_cnt", dut.byte_cnt, 3);
        check("starve_re", fifo_re, 0);
        check("starve_partial", word_out, 32'h00CCBBAA);
        push(8'hDD);
        #1;
        wait_valid(20, ok, waited);
        check("starve_resume_timeout", ok, 1);
        check("starve_resume_word", word_out, 32'hDDCCBBAA);
        check("starve_resume_bytes", word_bytes, 4);
        exp_q.push_back(32'hDDCCBBAA);
        tick();
`endif
        check_words();

        // Full FIFO drain: 16 bytes -> 4 words
        re_base = re_cnt;
        for (int b = 0; b < 16; b++) push(8'(b));
        #1;
        n = 0;
        while (got_w.size() < 4 && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", (got_w.size() >= 4) ? 1 : 0, 1);
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h07060504);
        exp_q.push_back(32'h0B0A0908);
        exp_q.push_back(32'h0F0E0D0C);
        check_words();
        check("drain_re_cnt", re_cnt - re_base, 16);
        check("drain_re_on_empty", re_on_empty, 0);

        // Reset mid-word: two bytes captured, third in flight, all discarded
        for (int b = 8'h20; b <= 8'h27; b++) push(8'(b));
        #1;
        tick();
        tick();
        tick();
        check("mid_pre_cnt", dut.byte_cnt, 2);
        check("mid_pre_word", word_out, 32'h00002120);
        rst = 1'b1;
        tick();
        check("mid_rst_cnt", dut.byte_cnt, 0);
        check("mid_rst_word", word_out, 0);
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_re", fifo_re, 0);
        rst = 1'b0;
        #1;
        wait_valid(30, ok, waited);
        check("mid_word_timeout", ok, 1);
        check("mid_word", word_out, 32'h26252423);
        check("mid_bytes", word_bytes, 4);
        exp_q.push_back(32'h26252423);
        tick();
        check_words();
        check("final_re_on_empty", re_on_empty, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
